// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bus bundle: the instruction-memory req/gnt/rvalid port and the
// valid/ready output register that feeds decode.
interface pc_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready;

    // Fetch unit side
    modport master (
        output imem_req, imem_addr, if_valid, if_pc, if_instr,
        input  imem_gnt, imem_rvalid, imem_rdata, if_ready
    );

    // Memory / decode side
    modport slave (
        input  imem_req, imem_addr, if_valid, if_pc, if_instr,
        output imem_gnt, imem_rvalid, imem_rdata, if_ready
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch stage. Keeps one memory request in
// flight, parks the returned word in a one-entry output register for decode,
// and handles redirects by flushing the output and dropping any stale response.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 32'd4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    output logic [31:0]            pc_plus4,
    pc_fetch_unit_if.master        bus
);

    localparam logic [31:0] STEP = 32'(PC_STEP);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_DROP = 3'd4
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [31:0] pc_r;
    logic [31:0] pc_s;
    logic        req_r;
    logic        valid_r;
    logic        valid_s;
    logic [31:0] if_pc_r;
    logic [31:0] if_instr_r;
    logic        capture_s;
    logic        consume_s;
    logic        flush_s;

    assign pc_plus4      = pc_r + STEP;
    assign bus.imem_req  = req_r;
    assign bus.imem_addr = pc_r;
    assign bus.if_valid  = valid_r;
    assign bus.if_pc     = if_pc_r;
    assign bus.if_instr  = if_instr_r;

    // Next-state, next-PC and output-slot decisions; redirect outranks everything outside IDLE.
    always_comb begin
        state_s   = state_r;
        pc_s      = pc_r;
        valid_s   = valid_r;
        capture_s = 1'b0;
        consume_s = valid_r && bus.if_ready;
        flush_s   = redirect && (state_r != S_IDLE);

        case (state_r)
            S_IDLE: begin
                state_s = S_REQ;
            end
            S_REQ: begin
                if (redirect) begin
                    pc_s    = redirect_pc;
                    // A granted request is already in flight; its response must be swallowed.
                    state_s = bus.imem_gnt ? S_DROP : S_REQ;
                end else begin
                    state_s = bus.imem_gnt ? S_WAIT : S_REQ;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    pc_s    = redirect_pc;
                    state_s = bus.imem_rvalid ? S_REQ : S_DROP;
                end else if (bus.imem_rvalid) begin
                    capture_s = 1'b1;
                    pc_s      = pc_plus4;
                    // Decode ready now is taken as the slot draining next cycle.
                    state_s   = bus.if_ready ? S_REQ : S_HOLD;
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_s    = redirect_pc;
                    state_s = S_REQ;
                end else begin
                    state_s = consume_s ? S_REQ : S_HOLD;
                end
            end
            S_DROP: begin
                if (redirect) begin
                    pc_s = redirect_pc;
                end else begin
                    pc_s = pc_r;
                end
                // The flushed response retires the drop even if a new redirect lands with it.
                state_s = bus.imem_rvalid ? S_REQ : S_DROP;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase

        if (flush_s) begin
            valid_s = 1'b0;
        end else if (capture_s) begin
            valid_s = 1'b1;
        end else if (consume_s) begin
            valid_s = 1'b0;
        end else begin
            valid_s = valid_r;
        end
    end

    // FSM state, PC and the registered request strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            pc_r    <= RESET_PC;
            req_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            req_r   <= (state_s == S_REQ);
        end
    end

    // One-entry output register toward decode; contents frozen unless a new word is captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r    <= 1'b0;
            if_pc_r    <= 32'h0000_0000;
            if_instr_r <= 32'h0000_0000;
        end else begin
            valid_r <= valid_s;
            if (capture_s) begin
                if_pc_r    <= pc_r;
                if_instr_r <= bus.imem_rdata;
            end else begin
                if_pc_r    <= if_pc_r;
                if_instr_r <= if_instr_r;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: a memory model answering grants after a
// programmable latency, and a {pc, instr} scoreboard filled as fetches are set up.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pc_plus4;

    pc_fetch_unit_if bus();

    pc_fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc_plus4    (pc_plus4),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic        gnt_en;
    int          lat;
    int          cnt;
    logic [31:0] gaddr;
    logic [63:0] exp_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[31:16], a[15:0]} ^ 32'h5A5A_0F0F;
    endfunction

    // Memory model: grants on the falling edge, answers 'lat' cycles after an accepted grant.
    always @(negedge clk) begin
        if (!rst_n) begin
            cnt             = 0;
            gaddr           = 32'h0;
            bus.imem_gnt    = 1'b0;
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = 32'h0;
        end else begin
            bus.imem_rvalid = 1'b0;
            if (bus.imem_gnt) cnt = lat;
            if (cnt > 0) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata  = mem_word(gaddr);
                end
            end
            bus.imem_gnt = bus.imem_req && gnt_en && (cnt == 0);
            if (bus.imem_gnt) gaddr = bus.imem_addr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic ready, input int latency);
        rst_n        = 1'b0;
        redirect     = 1'b0;
        redirect_pc  = 32'h0;
        bus.if_ready = ready;
        gnt_en       = 1'b1;
        lat          = latency;
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            ok = bus.if_valid;
        end
    endtask

    task automatic wait_req(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            ok = bus.imem_req;
        end
    endtask

    // Reset values, then first request and first delivered instruction.
    task automatic test_reset();
        bit          ok;
        logic [63:0] e;
        do_reset(1'b1, 1);
        rst_n = 1'b0;
        tick();
        tests_run++; if (bus.imem_req !== 1'b0) begin tests_failed++; $display("FAIL rst_req: got %b want 0", bus.imem_req); end
        tests_run++; if (bus.if_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_valid: got %b want 0", bus.if_valid); end
        tests_run++; if ({bus.if_pc, bus.if_instr} !== 64'h0) begin tests_failed++; $display("FAIL rst_data: got %h want 0", {bus.if_pc, bus.if_instr}); end
        tests_run++; if (pc_plus4 !== 32'h4) begin tests_failed++; $display("FAIL rst_pcp4: got %h want 00000004", pc_plus4); end
        rst_n = 1'b1;
        exp_q.push_back({32'h0, mem_word(32'h0)});
        tick();
        tests_run++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin tests_failed++; $display("FAIL first_req: got req=%b addr=%h want req=1 addr=0", bus.imem_req, bus.imem_addr); end
        wait_valid(10, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++; $display("FAIL first_valid: got timeout want if_valid");
        end else begin
            e = exp_q.pop_front();
            if ({bus.if_pc, bus.if_instr} !== e) begin tests_failed++; $display("FAIL first_instr: got %h want %h", {bus.if_pc, bus.if_instr}, e); end
        end
    endtask

    // Back-to-back streaming with decode always ready.
    task automatic test_back_to_back();
        logic [31:0] req_exp = 32'h0;
        logic [63:0] e;
        int          got  = 0;
        int          last = 0;
        do_reset(1'b1, 1);
        for (int k = 0; k < 4; k++) exp_q.push_back({32'(4 * k), mem_word(32'(4 * k))});
        for (int c = 0; c < 40 && got < 4; c++) begin
            tick();
            if (bus.imem_req) begin
                tests_run++; if (bus.imem_addr !== req_exp || pc_plus4 !== req_exp + 32'h4) begin tests_failed++; $display("FAIL stream_addr: got addr=%h pcp4=%h want addr=%h", bus.imem_addr, pc_plus4, req_exp); end
                req_exp = req_exp + 32'h4;
            end
            if (bus.if_valid && bus.if_ready) begin
                e = exp_q.pop_front();
                tests_run++; if ({bus.if_pc, bus.if_instr} !== e) begin tests_failed++; $display("FAIL stream_instr: got %h want %h", {bus.if_pc, bus.if_instr}, e); end
                if (got > 0) begin
                    tests_run++; if (c - last !== 2) begin tests_failed++; $display("FAIL stream_rate: got %0d cycles want 2", c - last); end
                end
                last = c;
                got++;
            end
        end
        tests_run++; if (got !== 4) begin tests_failed++; $display("FAIL stream_count: got %0d want 4", got); end
    endtask

    // Decode stalls: output held, no requests, resume fetches pc+4.
    task automatic test_backpressure();
        bit          ok;
        logic [63:0] e;
        do_reset(1'b0, 1);
        exp_q.push_back({32'h0, mem_word(32'h0)});
        exp_q.push_back({32'h4, mem_word(32'h4)});
        wait_valid(10, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++; $display("FAIL bp_valid: got timeout want if_valid");
        end else begin
            for (int c = 0; c < 5; c++) begin
                tick();
                tests_run++; if (bus.imem_req !== 1'b0 || bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0 || bus.if_instr !== mem_word(32'h0)) begin tests_failed++; $display("FAIL bp_hold: got req=%b v=%b pc=%h instr=%h want 0 1 0 %h", bus.imem_req, bus.if_valid, bus.if_pc, bus.if_instr, mem_word(32'h0)); end
            end
            bus.if_ready = 1'b1;
            e = exp_q.pop_front();
            tests_run++; if ({bus.if_pc, bus.if_instr} !== e) begin tests_failed++; $display("FAIL bp_instr: got %h want %h", {bus.if_pc, bus.if_instr}, e); end
            tick();
            tests_run++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4) begin tests_failed++; $display("FAIL bp_resume: got req=%b addr=%h want 1 00000004", bus.imem_req, bus.imem_addr); end
            wait_valid(10, ok);
            e = exp_q.pop_front();
            tests_run++; if (!ok || {bus.if_pc, bus.if_instr} !== e) begin tests_failed++; $display("FAIL bp_next: got ok=%b %h want %h", ok, {bus.if_pc, bus.if_instr}, e); end
        end
    endtask

    // Redirect in WAIT before the response: stale word dropped, refetch at target.
    task automatic test_redirect_drop();
        bit          ok;
        bit          seen_req = 1'b0;
        bit          found    = 1'b0;
        logic [63:0] e;
        do_reset(1'b1, 3);
        wait_req(5, ok);
        tests_run++; if (!ok || bus.imem_addr !== 32'h0) begin tests_failed++; $display("FAIL rd_first: got ok=%b addr=%h want 1 0", ok, bus.imem_addr); end
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        exp_q.push_back({32'h100, mem_word(32'h100)});
        tick();
        redirect = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            tick();
            if (bus.imem_req && !seen_req) begin
                seen_req = 1'b1;
                tests_run++; if (bus.imem_addr !== 32'h100) begin tests_failed++; $display("FAIL rd_addr: got %h want 00000100", bus.imem_addr); end
            end
            if (bus.if_valid) begin
                found = 1'b1;
                e = exp_q.pop_front();
                tests_run++; if (!seen_req || {bus.if_pc, bus.if_instr} !== e) begin tests_failed++; $display("FAIL rd_instr: got req_seen=%b %h want 1 %h", seen_req, {bus.if_pc, bus.if_instr}, e); end
            end
        end
        tests_run++; if (!found) begin tests_failed++; $display("FAIL rd_timeout: got no if_valid want one"); end
    endtask

    // Redirect to the top word of the address space; sequential PC wraps to zero.
    task automatic test_wrap();
        bit          ok;
        int          reqs  = 0;
        bit          found = 1'b0;
        logic [63:0] e;
        do_reset(1'b1, 1);
        wait_req(5, ok);
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        exp_q.push_back({32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC)});
        tick();
        redirect = 1'b0;
        for (int c = 0; c < 20 && !(found && reqs == 2); c++) begin
            tick();
            if (bus.imem_req && reqs == 0) begin
                tests_run++; if (bus.imem_addr !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin tests_failed++; $display("FAIL wrap_top: got addr=%h pcp4=%h want fffffffc 0", bus.imem_addr, pc_plus4); end
                reqs++;
            end else if (bus.imem_req && reqs == 1) begin
                tests_run++; if (bus.imem_addr !== 32'h0 || pc_plus4 !== 32'h4) begin tests_failed++; $display("FAIL wrap_zero: got addr=%h pcp4=%h want 0 4", bus.imem_addr, pc_plus4); end
                reqs++;
            end
            if (bus.if_valid && !found) begin
                found = 1'b1;
                e = exp_q.pop_front();
                tests_run++; if ({bus.if_pc, bus.if_instr} !== e) begin tests_failed++; $display("FAIL wrap_instr: got %h want %h", {bus.if_pc, bus.if_instr}, e); end
            end
        end
        tests_run++; if (!found || reqs !== 2) begin tests_failed++; $display("FAIL wrap_timeout: got found=%b reqs=%0d want 1 2", found, reqs); end
    endtask

    // Asynchronous reset while a fetch is in flight and the output is still held.
    task automatic test_reset_mid();
        bit          ok;
        logic [63:0] e;
        do_reset(1'b1, 3);
        exp_q.push_back({32'h0, mem_word(32'h0)});
        wait_valid(15, ok);
        e = exp_q.pop_front();
        tests_run++; if (!ok || {bus.if_pc, bus.if_instr} !== e) begin tests_failed++; $display("FAIL mid_first: got ok=%b %h want 1 %h", ok, {bus.if_pc, bus.if_instr}, e); end
        bus.if_ready = 1'b0;
        tick();
        tests_run++; if (bus.if_valid !== 1'b1 || bus.imem_req !== 1'b0) begin tests_failed++; $display("FAIL mid_wait: got v=%b req=%b want 1 0", bus.if_valid, bus.imem_req); end
        rst_n = 1'b0;
        #1;
        tests_run++; if (bus.imem_req !== 1'b0 || bus.if_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_ctl: got req=%b v=%b want 0 0", bus.imem_req, bus.if_valid); end
        tests_run++; if ({bus.if_pc, bus.if_instr} !== 64'h0 || pc_plus4 !== 32'h4) begin tests_failed++; $display("FAIL mid_rst_data: got %h pcp4=%h want 0 4", {bus.if_pc, bus.if_instr}, pc_plus4); end
        tick();
        bus.if_ready = 1'b1;
        rst_n        = 1'b1;
        tick();
        tests_run++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin tests_failed++; $display("FAIL mid_restart: got req=%b addr=%h want 1 0", bus.imem_req, bus.imem_addr); end
    endtask

    initial begin
        rst_n        = 1'b0;
        redirect     = 1'b0;
        redirect_pc  = 32'h0;
        bus.if_ready = 1'b0;
        gnt_en       = 1'b0;
        lat          = 1;
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_redirect_drop();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
